// File: rtl/imem_boot_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to instruction
// memory and holds the CPU in reset until done. Optional checksum: IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W     = 8,
    parameter int WORD_COUNT = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       byte_in,
    input  logic                             byte_valid,
    output logic                             byte_ready,
    output logic                             im_we,
    output logic [ADDR_W-1:0]                im_addr,
    output logic [31:0]                      im_wdata,
    output logic                             cpu_reset,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(WORD_COUNT+1)-1:0]  words_loaded
);

    localparam int WL_W = $clog2(WORD_COUNT + 1);
    localparam logic [WL_W-1:0] WL_ONE  = WL_W'(1);
    localparam logic [WL_W-1:0] WL_LAST = WL_W'(WORD_COUNT - 1);
    localparam logic [WL_W-1:0] WL_MAX  = WL_W'(WORD_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        ST_CHECK,
        ST_ERROR,
`endif
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic [31:0]       word_reg, word_next;
    logic [31:0]       packed_word;
    logic [WL_W-1:0]   words_loaded_reg, words_loaded_next;
    logic              im_we_reg, im_we_next;
    logic [ADDR_W-1:0] im_addr_reg, im_addr_next;
    logic [31:0]       im_wdata_reg, im_wdata_next;
    logic              byte_ready_reg, byte_ready_next;
    logic              cpu_reset_reg, cpu_reset_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              take;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0]       sum_reg, sum_next;
    logic              error_reg, error_next;
`endif

    always_comb begin
        state_next        = state_reg;
        byte_idx_next     = byte_idx_reg;
        word_next         = word_reg;
        words_loaded_next = words_loaded_reg;
        im_we_next        = 1'b0;
        im_addr_next      = im_addr_reg;
        im_wdata_next     = im_wdata_reg;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        sum_next          = sum_reg;
`endif
        // byte_ready_reg is only high in LOAD/CHECK, so it doubles as the acceptance gate
        take        = byte_valid && byte_ready_reg;
        packed_word = word_reg;
        case (byte_idx_reg)
            2'd0:    packed_word[31:24] = byte_in;
            2'd1:    packed_word[23:16] = byte_in;
            2'd2:    packed_word[15:8]  = byte_in;
            default: packed_word[7:0]   = byte_in;
        endcase

        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (take) begin
                    word_next     = packed_word;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next    = ST_WRITE;
                        im_we_next    = 1'b1;
                        im_addr_next  = ADDR_W'({words_loaded_reg, 2'b00});
                        im_wdata_next = packed_word;
                    end
                end
            end
            ST_WRITE: begin
                byte_idx_next = 2'd0;
                word_next     = 32'd0;
                if (words_loaded_reg != WL_MAX) words_loaded_next = words_loaded_reg + WL_ONE;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                sum_next = sum_reg + im_wdata_reg;
                if (words_loaded_reg == WL_LAST) state_next = ST_CHECK;
                else                             state_next = ST_LOAD;
`else
                if (words_loaded_reg == WL_LAST) state_next = ST_DONE;
                else                             state_next = ST_LOAD;
`endif
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (take) begin
                    word_next     = packed_word;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3)
                        state_next = (packed_word == sum_reg) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: ;
        endcase

        // Status outputs are registered images of the state being entered
        byte_ready_next = (state_next == ST_LOAD);
        busy_next       = (state_next == ST_LOAD) || (state_next == ST_WRITE);
        done_next       = (state_next == ST_DONE);
        cpu_reset_next  = (state_next != ST_DONE);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        byte_ready_next = byte_ready_next || (state_next == ST_CHECK);
        busy_next       = busy_next || (state_next == ST_CHECK);
        error_next      = (state_next == ST_ERROR);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            byte_idx_reg     <= 2'd0;
            word_reg         <= 32'd0;
            words_loaded_reg <= '0;
            im_we_reg        <= 1'b0;
            im_addr_reg      <= '0;
            im_wdata_reg     <= 32'd0;
            byte_ready_reg   <= 1'b0;
            cpu_reset_reg    <= 1'b1;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_reg          <= 32'd0;
            error_reg        <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            byte_idx_reg     <= byte_idx_next;
            word_reg         <= word_next;
            words_loaded_reg <= words_loaded_next;
            im_we_reg        <= im_we_next;
            im_addr_reg      <= im_addr_next;
            im_wdata_reg     <= im_wdata_next;
            byte_ready_reg   <= byte_ready_next;
            cpu_reset_reg    <= cpu_reset_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_reg          <= sum_next;
            error_reg        <= error_next;
`endif
        end
    end

    assign byte_ready   = byte_ready_reg;
    assign im_we        = im_we_reg;
    assign im_addr      = im_addr_reg;
    assign im_wdata     = im_wdata_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign words_loaded = words_loaded_reg;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    assign error        = error_reg;
`else
    assign error        = 1'b0;
`endif

endmodule
